serializer_feeder: RTL and testbench
====================================

// Module: serializer_feeder
// PURPOSE
//  Byte queue directly upstream of the serializer. Buffers parallel words from the producer in a FIFO.
//  Launches them one at a time into the serializer via data_in/start, paced by its busy output.
//  Decouples bursty producers from the serializer's 1-word-per-DATA_WIDTH-cycle drain rate.
// PARAMETERS
//  DATA_WIDTH  8                    word width; must match the serializer's DATA_WIDTH
//  DEPTH       16                   FIFO entries; power of two, >=2
//  ADDR_WIDTH  $clog2(DEPTH)        FIFO pointer width (derived, do not override)
//  LAUNCH_TO   3                    cycles to wait for ser_busy rise before flagging launch_err
// PORTS
//  clock       in   1               rising-edge clock, shared with the serializer
//  reset       in   1               reset, synchronous, active-high
//  wr_data     in   DATA_WIDTH      word to enqueue
//  wr_en       in   1               enqueue request, sampled each rising edge
//  full        out  1               FIFO holds DEPTH words; writes are dropped
//  empty       out  1               FIFO holds 0 words
//  count       out  ADDR_WIDTH+1    words currently queued, excluding the word in flight
//  overflow    out  1               sticky: a write was dropped while full
//  launch_err  out  1               sticky: ser_busy did not rise within LAUNCH_TO cycles of a start
//  ser_data    out  DATA_WIDTH      to serializer data_in; registered
//  ser_start   out  1               to serializer start; registered single-cycle pulse
//  ser_busy    in   1               from serializer busy
// BEHAVIOUR
//  Reset values: full=0, empty=1, count=0, overflow=0, launch_err=0, ser_start=0, ser_data=0.
//  Reset: state=IDLE, pointers=0. Reset mid-transfer flushes the FIFO and discards the in-flight word.
//  Write: accepted iff wr_en && !full, with full taken from the registered count.
//   A write while full is dropped and sets overflow, even if a pop occurs in the same cycle.
//  Pop and write in the same cycle: count is unchanged. Pointers wrap modulo DEPTH.
//  No fall-through: a word written at edge N is launchable at edge N+1 at the earliest.
//  FSM (registered state):
//   IDLE: if !empty && !ser_busy at edge -> ser_data<=head, ser_start<=1, pop, go LAUNCH.
//         Otherwise hold ser_start=0 and keep ser_data at its last value.
//   LAUNCH: ser_start<=0, ser_data held stable, timeout counter cleared; go WAIT_BUSY.
//           The serializer captures data_in on the edge where it samples start=1.
//   WAIT_BUSY: if ser_busy -> go WAIT_DONE.
//              Else count; after LAUNCH_TO cycles set launch_err and go IDLE. The word is lost, not re-queued.
//   WAIT_DONE: if !ser_busy -> go IDLE; the next launch can occur on the following edge.
//  ser_start is never high in two consecutive cycles. It never rises while ser_busy=1 or while state!=IDLE.
//  If ser_busy=1 at reset release (serializer not reset together), IDLE waits for it to fall.
//  Sustained throughput: one word per DATA_WIDTH+3 cycles with the reference serializer timing.
//  overflow and launch_err clear only on reset.
// TESTING
//  1 Single word: wr 0xA5 at edge N into empty FIFO, serializer model attached.
//    -> ser_start=1 and ser_data=0xA5 in the cycle after edge N+1, exactly one cycle wide.
//    -> serial stream 1,0,1,0,0,1,0,1 (LSB first); count returns to 0.
//  2 Burst: write 0x01..0x10 on 16 back-to-back cycles (DEPTH=16).
//    -> no overflow; all 16 words emerge in order; full never asserted, since the first word pops early.
//  3 Overflow: hold ser_busy=1 and write 17 words.
//    -> full=1 and count=16 after 16 writes; 17th dropped; overflow=1; first word out is still word 1.
//  4 Simultaneous: at count=16 with wr_en and pop in the same cycle.
//    -> write dropped, overflow=1, count=15. At count=5 with wr_en and pop together -> count stays 5.
//  5 Launch timeout: tie ser_busy=0 after one start.
//    -> launch_err=1 LAUNCH_TO cycles after WAIT_BUSY entry; next word launches afterwards.
//  6 Reset mid-operation: assert reset while 3 words queued and one in flight.
//    -> next cycle: count=0, empty=1, ser_start=0; no further start pulses until a new write.

Source files
------------

// File: rtl/serializer_feeder.sv
// Word FIFO feeding a bit serializer: buffers producer writes and
// launches one word at a time via a registered start pulse paced by busy.
module serializer_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int LAUNCH_TO  = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  wr_en_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic                  overflow_o,
    output logic                  launch_err_o,
    output logic [DATA_WIDTH-1:0] ser_data_o,
    output logic                  ser_start_o,
    input  logic                  ser_busy_i
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam int TW = $clog2(LAUNCH_TO) + 1;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [TW-1:0]         tmr_q, tmr_d;
    logic                  ovf_q, ovf_d;
    logic                  err_q, err_d;
    logic                  start_q, start_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  full, empty, push, pop;

    // Flags come from the registered count, so a word written this
    // cycle is not visible to the launch logic until the next edge.
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign push  = wr_en_i && !full;

    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q;
        start_d  = 1'b0;
        data_d   = data_q;
        err_d    = err_q;
        pop      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty && !ser_busy_i) begin
                    pop     = 1'b1;
                    start_d = 1'b1;
                    data_d  = mem_q[rd_ptr_q];
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                tmr_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (ser_busy_i) begin
                    state_d = WAIT_DONE;
                end else if (tmr_q == TW'(LAUNCH_TO - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            WAIT_DONE: begin
                if (!ser_busy_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(push);
        rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
        // A dropped write is flagged even when a pop frees a slot this cycle.
        ovf_d    = ovf_q | (wr_en_i && full);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            tmr_q    <= '0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
            start_q  <= 1'b0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            tmr_q    <= tmr_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
            start_q  <= start_d;
            data_q   <= data_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign full_o       = full;
    assign empty_o      = empty;
    assign count_o      = count_q;
    assign overflow_o   = ovf_q;
    assign launch_err_o = err_q;
    assign ser_data_o   = data_q;
    assign ser_start_o  = start_q;

endmodule

// File: tb/tb_serializer_feeder.sv
// Bench for serializer_feeder: vector table, directed corner cases and
// randomized traffic scored against a queue model with a serializer model.
module tb_serializer_feeder;

    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic [DW-1:0] wr_data_i;
    logic          wr_en_i;
    logic          full_o, empty_o, overflow_o, launch_err_o;
    logic [4:0]    count_o;
    logic [DW-1:0] ser_data_o;
    logic          ser_start_o;
    logic          ser_busy;

    logic          force_en, force_val;
    logic          mbusy;
    logic [DW-1:0] msh;
    int            mcnt;

    int total = 0;
    int passed = 0;

    logic [DW-1:0] launched[$];
    logic [DW-1:0] mq[$];
    bit            model_on = 0;
    bit            ovf_m;
    bit            full_seen;

    always #5 clock = ~clock;

    assign ser_busy = force_en ? force_val : mbusy;

    serializer_feeder dut (
        .clock        (clock),
        .reset        (reset),
        .wr_data_i    (wr_data_i),
        .wr_en_i      (wr_en_i),
        .full_o       (full_o),
        .empty_o      (empty_o),
        .count_o      (count_o),
        .overflow_o   (overflow_o),
        .launch_err_o (launch_err_o),
        .ser_data_o   (ser_data_o),
        .ser_start_o  (ser_start_o),
        .ser_busy_i   (ser_busy)
    );

    // Reference serializer: captures on start, shifts LSB first for DW cycles.
    always_ff @(posedge clock) begin
        if (reset) begin
            mbusy <= 1'b0;
            msh   <= '0;
            mcnt  <= 0;
        end else if (!mbusy) begin
            if (ser_start_o) begin
                msh   <= ser_data_o;
                mcnt  <= DW;
                mbusy <= 1'b1;
            end
        end else begin
            if (mcnt == 1) mbusy <= 1'b0;
            msh  <= msh >> 1;
            mcnt <= mcnt - 1;
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        bit            p_wr    = wr_en_i;
        logic [DW-1:0] p_d     = wr_data_i;
        bit            p_rst   = reset;
        bit            p_busy  = ser_busy;
        bit            p_start = ser_start_o;
        bit            acc;
        @(posedge clock);
        #1;
        if (ser_start_o) launched.push_back(ser_data_o);
        if (full_o) full_seen = 1;
        if (model_on) begin
            if (p_rst) begin
                mq.delete();
                ovf_m = 0;
            end else begin
                acc = p_wr && (mq.size() < DEPTH);
                if (p_wr && !acc) ovf_m = 1;
                if (ser_start_o) begin
                    if (mq.size() == 0) chk("pop_from_empty", 1, 0);
                    else chk("launch_order", 32'(ser_data_o), 32'(mq.pop_front()));
                    chk("start_while_busy", 32'(p_busy), 0);
                    chk("start_back_to_back", 32'(p_start), 0);
                end
                if (acc) mq.push_back(p_d);
            end
            chk("rand_count", 32'(count_o), 32'(mq.size()));
            chk("rand_overflow", 32'(overflow_o), 32'(ovf_m));
            chk("rand_launch_err", 32'(launch_err_o), 0);
        end
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        wr_en_i = 1'b0;
        tick();
        reset   = 1'b0;
    endtask

    task automatic wait_launches(int n, int budget);
        int c = 0;
        while (launched.size() < n && c < budget) begin
            tick();
            c++;
        end
        chk("launch_wait_bound", 32'(launched.size() >= n), 1);
    endtask

    typedef struct {
        bit            rst;
        bit            wr;
        logic [DW-1:0] d;
        bit            busy;
        int            cnt;
        bit            full;
        bit            empty;
        bit            start;
        logic [DW-1:0] data;
        bit            ovf;
        bit            err;
    } vec_t;

    vec_t tbl[15];

    initial begin
        logic [DW-1:0] word;
        int            nb;
        int            starts;

        reset     = 1'b1;
        wr_en_i   = 1'b0;
        wr_data_i = '0;
        force_en  = 1'b1;
        force_val = 1'b0;

        // Launch, handshake, then a timeout with busy stuck low.
        tbl[0]  = '{1, 0, 8'h00, 1, 0, 0, 1, 0, 8'h00, 0, 0};
        tbl[1]  = '{0, 1, 8'h11, 1, 1, 0, 0, 0, 8'h00, 0, 0};
        tbl[2]  = '{0, 1, 8'h22, 1, 2, 0, 0, 0, 8'h00, 0, 0};
        tbl[3]  = '{0, 0, 8'h00, 0, 1, 0, 0, 1, 8'h11, 0, 0};
        tbl[4]  = '{0, 1, 8'h33, 0, 2, 0, 0, 0, 8'h11, 0, 0};
        tbl[5]  = '{0, 0, 8'h00, 1, 2, 0, 0, 0, 8'h11, 0, 0};
        tbl[6]  = '{0, 0, 8'h00, 1, 2, 0, 0, 0, 8'h11, 0, 0};
        tbl[7]  = '{0, 0, 8'h00, 0, 2, 0, 0, 0, 8'h11, 0, 0};
        tbl[8]  = '{0, 0, 8'h00, 0, 1, 0, 0, 1, 8'h22, 0, 0};
        tbl[9]  = '{0, 0, 8'h00, 0, 1, 0, 0, 0, 8'h22, 0, 0};
        tbl[10] = '{0, 0, 8'h00, 0, 1, 0, 0, 0, 8'h22, 0, 0};
        tbl[11] = '{0, 0, 8'h00, 0, 1, 0, 0, 0, 8'h22, 0, 0};
        tbl[12] = '{0, 0, 8'h00, 0, 1, 0, 0, 0, 8'h22, 0, 1};
        tbl[13] = '{0, 0, 8'h00, 0, 0, 0, 1, 1, 8'h33, 0, 1};
        tbl[14] = '{0, 0, 8'h00, 0, 0, 0, 1, 0, 8'h33, 0, 1};

        for (int i = 0; i < 15; i++) begin
            reset     = tbl[i].rst;
            wr_en_i   = tbl[i].wr;
            wr_data_i = tbl[i].d;
            force_val = tbl[i].busy;
            tick();
            chk($sformatf("vec%0d count", i), 32'(count_o), 32'(tbl[i].cnt));
            chk($sformatf("vec%0d full", i), 32'(full_o), 32'(tbl[i].full));
            chk($sformatf("vec%0d empty", i), 32'(empty_o), 32'(tbl[i].empty));
            chk($sformatf("vec%0d start", i), 32'(ser_start_o), 32'(tbl[i].start));
            chk($sformatf("vec%0d data", i), 32'(ser_data_o), 32'(tbl[i].data));
            chk($sformatf("vec%0d overflow", i), 32'(overflow_o), 32'(tbl[i].ovf));
            chk($sformatf("vec%0d launch_err", i), 32'(launch_err_o), 32'(tbl[i].err));
        end

        // Single word through the attached serializer model.
        force_en = 1'b0;
        do_reset();
        wr_en_i   = 1'b1;
        wr_data_i = 8'hA5;
        tick();
        wr_en_i = 1'b0;
        chk("t1 count after write", 32'(count_o), 1);
        chk("t1 no fall-through", 32'(ser_start_o), 0);
        tick();
        chk("t1 start", 32'(ser_start_o), 1);
        chk("t1 data", 32'(ser_data_o), 32'h A5);
        chk("t1 count after pop", 32'(count_o), 0);
        tick();
        chk("t1 start width", 32'(ser_start_o), 0);
        word = '0;
        nb   = 0;
        for (int i = 0; i < 20; i++) begin
            if (mbusy && nb < DW) begin
                word[nb] = msh[0];
                nb++;
            end
            tick();
        end
        chk("t1 serial bits", 32'(nb), DW);
        chk("t1 serial word", 32'(word), 32'h A5);

        // Burst of 16 back-to-back writes.
        do_reset();
        launched.delete();
        full_seen = 0;
        for (int i = 1; i <= 16; i++) begin
            wr_en_i   = 1'b1;
            wr_data_i = DW'(i);
            tick();
        end
        wr_en_i = 1'b0;
        wait_launches(16, 400);
        for (int i = 0; i < 16 && i < launched.size(); i++)
            chk($sformatf("t2 word%0d", i), 32'(launched[i]), 32'(i + 1));
        chk("t2 overflow", 32'(overflow_o), 0);
        chk("t2 full never", 32'(full_seen), 0);

        // Overflow with serializer held busy.
        force_en  = 1'b1;
        force_val = 1'b1;
        do_reset();
        launched.delete();
        for (int i = 1; i <= 16; i++) begin
            wr_en_i   = 1'b1;
            wr_data_i = DW'(8'h80 + i);
            tick();
        end
        chk("t3 full", 32'(full_o), 1);
        chk("t3 count", 32'(count_o), 16);
        chk("t3 overflow before", 32'(overflow_o), 0);
        wr_data_i = 8'hEE;
        tick();
        wr_en_i = 1'b0;
        chk("t3 overflow", 32'(overflow_o), 1);
        chk("t3 count held", 32'(count_o), 16);
        force_en = 1'b0;
        wait_launches(1, 20);
        if (launched.size() > 0) chk("t3 first word", 32'(launched[0]), 32'h81);

        // Write and pop on the same edge, full and partially filled.
        force_en  = 1'b1;
        force_val = 1'b1;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            wr_en_i   = 1'b1;
            wr_data_i = DW'(i);
            tick();
        end
        force_val = 1'b0;
        wr_data_i = 8'h77;
        tick();
        wr_en_i = 1'b0;
        chk("t4 pop at full", 32'(ser_start_o), 1);
        chk("t4 count full+pop", 32'(count_o), 15);
        chk("t4 overflow full+pop", 32'(overflow_o), 1);
        force_val = 1'b1;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            wr_en_i   = 1'b1;
            wr_data_i = DW'(i);
            tick();
        end
        force_val = 1'b0;
        tick();
        wr_en_i = 1'b0;
        chk("t4 pop at 5", 32'(ser_start_o), 1);
        chk("t4 count 5", 32'(count_o), 5);
        chk("t4 overflow 5", 32'(overflow_o), 0);

        // Reset while words are queued and one is in flight.
        force_en = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            wr_en_i   = 1'b1;
            wr_data_i = DW'(8'h40 + i);
            tick();
        end
        wr_en_i = 1'b0;
        chk("t6 count before", 32'(count_o), 3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6 count", 32'(count_o), 0);
        chk("t6 empty", 32'(empty_o), 1);
        chk("t6 start", 32'(ser_start_o), 0);
        starts = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ser_start_o) starts++;
        end
        chk("t6 no starts", 32'(starts), 0);
        launched.delete();
        wr_en_i   = 1'b1;
        wr_data_i = 8'h5A;
        tick();
        wr_en_i = 1'b0;
        wait_launches(1, 20);
        if (launched.size() > 0) chk("t6 new word", 32'(launched[0]), 32'h5A);

        // Random traffic against the queue model.
        force_en = 1'b0;
        model_on = 1;
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            wr_en_i   = ($urandom_range(0, 99) < (((i / 250) % 2 == 0) ? 90 : 8));
            wr_data_i = DW'($urandom);
            tick();
        end
        wr_en_i = 1'b0;
        for (int i = 0; i < 250; i++) tick();
        model_on = 0;
        chk("rand drained", 32'(count_o), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
